// File: rtl/pipe_word_serializer_pkg.sv
// Shared definitions for the pipe word serializer.
// Header layout (top 32 bits of a message): {method id[15:0], word count[15:0]}.
package pipe_word_serializer_pkg;

  localparam int WORD_BITS = 32;
  localparam int HDR_BITS  = 32;
  localparam int CNT_BITS  = 16;

  // Bit offsets inside the header word
  localparam int ID_MSB    = HDR_BITS - 1;
  localparam int CNT_MSB   = ID_MSB - 16;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] cnt;
  } hdr_t;

  // Zero or oversize counts are clamped to the full message length
  function automatic logic [CNT_BITS-1:0] legal_cnt(input logic [CNT_BITS-1:0] cnt,
                                                    input logic [CNT_BITS-1:0] nwords);
    return ((cnt == '0) || (cnt > nwords)) ? nwords : cnt;
  endfunction

endpackage

// File: rtl/pipe_word_serializer_fifo.sv
// msg_fifo: DEPTH-entry register FIFO, W bits wide.
// Ports: CLK, nRST (async active-low), push/din write side, pop/dout read side
// (dout shows the head entry), full/empty status from registered occupancy.
// Push while full and pop while empty are ignored.
module msg_fifo #(
  parameter int W     = 144,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr_q];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr_q] <= din;
        wptr_q      <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_word_serializer.sv
// pipe_word_serializer: buffers whole marshalled messages and emits each as a
// burst of 32-bit words, header word first, MSB-first.
// Ports:
//   CLK, nRST           clock, async active-low reset
//   enq__ENA/enq_v      message offer / message ({id, cnt, args...} from the top)
//   enq__RDY            message FIFO has room
//   out__ENA/out_v      word valid / word to the sink
//   out_last            current word ends the message
//   out__RDY            sink accepts the word
//   len_err             sticky flag: a message carried an illegal word count
//   msg_count           messages fully emitted (wraps)
module pipe_word_serializer
  import pipe_word_serializer_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              enq__ENA,
  input  logic [WIDTH-1:0]  enq_v,
  output logic              enq__RDY,
  output logic              out__ENA,
  output logic [31:0]       out_v,
  output logic              out_last,
  input  logic              out__RDY,
  output logic              len_err,
  output logic [15:0]       msg_count
);

  localparam int NWORDS = WIDTH / WORD_BITS;
  localparam logic [CNT_BITS-1:0] NW16 = CNT_BITS'(NWORDS);

  typedef struct packed {
    logic [CNT_BITS-1:0] cnt;
    logic [WIDTH-1:0]    payload;
  } entry_t;

  entry_t              push_entry;
  entry_t              head;
  logic [$bits(entry_t)-1:0] head_raw;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [CNT_BITS-1:0] enq_cnt;
  logic                cnt_bad;

  ser_state_e          state_q, state_d;
  logic [WIDTH-1:0]    sreg_q, sreg_d;
  logic [CNT_BITS-1:0] rem_q, rem_d;
  logic                last_q, last_d;
  logic                ena_q, ena_d;
  logic                len_err_q, len_err_d;
  logic [15:0]         msg_count_q, msg_count_d;
  logic                run_q;

  assign enq_cnt = enq_v[WIDTH-HDR_BITS+CNT_MSB -: CNT_BITS];
  assign cnt_bad = (enq_cnt == '0) || (enq_cnt > NW16);

  // run_q keeps enq__RDY low through reset without a combinational path from nRST
  assign enq__RDY           = run_q && !full;
  assign push               = enq__ENA && enq__RDY;
  assign push_entry.cnt     = legal_cnt(enq_cnt, NW16);
  assign push_entry.payload = enq_v;
  assign head               = entry_t'(head_raw);

  msg_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_raw),
    .full  (full),
    .empty (empty)
  );

  // The presented word is the top slice of the shift register.
  assign out__ENA  = ena_q;
  assign out_v     = sreg_q[WIDTH-1 -: WORD_BITS];
  assign out_last  = last_q;
  assign len_err   = len_err_q;
  assign msg_count = msg_count_q;

  always_comb begin
    logic load;
    state_d     = state_q;
    sreg_d      = sreg_q;
    rem_d       = rem_q;
    last_d      = last_q;
    ena_d       = ena_q;
    len_err_d   = len_err_q | (push && cnt_bad);
    msg_count_d = msg_count_q;
    pop         = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          load = 1'b1;
        end
      end
      SEND: begin
        if (out__RDY) begin
          if (!last_q) begin
            sreg_d = sreg_q << WORD_BITS;
            rem_d  = rem_q - 1'b1;
            last_d = (rem_q == 16'd1);
          end else begin
            msg_count_d = msg_count_q + 16'd1;
            if (!empty) begin
              load = 1'b1;
            end else begin
              ena_d   = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared by the IDLE start and the back-to-back reload after a final word
    if (load) begin
      pop     = 1'b1;
      sreg_d  = head.payload;
      rem_d   = head.cnt - 1'b1;
      last_d  = (head.cnt == 16'd1);
      ena_d   = 1'b1;
      state_d = SEND;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      rem_q       <= '0;
      last_q      <= 1'b0;
      ena_q       <= 1'b0;
      len_err_q   <= 1'b0;
      msg_count_q <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      rem_q       <= rem_d;
      last_q      <= last_d;
      ena_q       <= ena_d;
      len_err_q   <= len_err_d;
      msg_count_q <= msg_count_d;
      run_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_word_serializer.sv
module tb_pipe_word_serializer;

  localparam int WIDTH = 128;
  localparam int DEPTH = 2;
  localparam int NW    = WIDTH / 32;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              enq__ENA;
  logic [WIDTH-1:0]  enq_v;
  logic              enq__RDY;
  logic              out__ENA;
  logic [31:0]       out_v;
  logic              out_last;
  logic              out__RDY;
  logic              len_err;
  logic [15:0]       msg_count;

  pipe_word_serializer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .enq__ENA  (enq__ENA),
    .enq_v     (enq_v),
    .enq__RDY  (enq__RDY),
    .out__ENA  (out__ENA),
    .out_v     (out_v),
    .out_last  (out_last),
    .out__RDY  (out__RDY),
    .len_err   (len_err),
    .msg_count (msg_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] w;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          xfers = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  int          exp_msgs = 0;
  logic        exp_len_err = 1'b0;
  logic        accepted = 1'b0;
  logic        rand_rdy = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] hold_v = '0;
  logic        hold_l = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input logic [15:0] id, input logic [15:0] cnt,
                                          input logic [31:0] a0, input logic [31:0] a1,
                                          input logic [31:0] a2);
    return {id, cnt, a0, a1, a2};
  endfunction

  // Reference: a message becomes its first cnt words (cnt clamped to NW when 0 or too big)
  task automatic model_push(input logic [WIDTH-1:0] m);
    int   cnt;
    exp_t e;
    cnt = int'(m[WIDTH-17 -: 16]);
    if (cnt == 0 || cnt > NW) begin
      cnt = NW;
      exp_len_err = 1'b1;
    end
    for (int i = 0; i < cnt; i++) begin
      e.w    = m[WIDTH-1-32*i -: 32];
      e.last = (i == cnt - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock: observe handshakes at the negedge, return 1 time unit after the posedge
  task automatic tick();
    exp_t e;
    @(negedge CLK);
    if (hold) begin
      chk("hold_ena", 32'(out__ENA), 32'd1);
      chk("hold_v", out_v, hold_v);
      chk("hold_last", 32'(out_last), 32'(hold_l));
      hold = 1'b0;
    end
    if (enq__ENA && enq__RDY) begin
      model_push(enq_v);
      accepted = 1'b1;
    end
    if (out__ENA) begin
      if (out__RDY) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", 32'(out__ENA), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("word", out_v, e.w);
          chk("last", 32'(out_last), 32'(e.last));
          if (e.last) exp_msgs++;
          if (xfers == 0) first_cyc = cyc;
          last_cyc = cyc;
          xfers++;
        end
      end else begin
        hold   = 1'b1;
        hold_v = out_v;
        hold_l = out_last;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (rand_rdy) out__RDY = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [WIDTH-1:0] m);
    enq_v    = m;
    enq__ENA = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 300 && !accepted; k++) tick();
    enq__ENA = 1'b0;
    if (!accepted) chk("send_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) tick();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clr_x();
    xfers = 0;
  endtask

  initial begin
    int base;
    nRST     = 1'b0;
    enq__ENA = 1'b0;
    enq_v    = '0;
    out__RDY = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_rdy", 32'(enq__RDY), 32'd0);
    chk("rst_ena", 32'(out__ENA), 32'd0);
    chk("rst_v", out_v, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_lenerr", 32'(len_err), 32'd0);
    chk("rst_count", 32'(msg_count), 32'd0);
    nRST = 1'b1;
    tick();

    // Header-only message, latency N+2
    clr_x();
    send(mk(16'h0000, 16'd1, 32'h0, 32'h0, 32'h0));
    chk("lat_n1_ena", 32'(out__ENA), 32'd0);
    tick();
    chk("lat_n2_ena", 32'(out__ENA), 32'd1);
    chk("lat_n2_v", out_v, 32'h0000_0001);
    chk("lat_n2_last", 32'(out_last), 32'd1);
    drain();
    chk("hdr_count", 32'(msg_count), 32'd1);

    // 4-word message, consecutive cycles
    clr_x();
    send(mk(16'h0002, 16'd4, 32'hA, 32'hB, 32'hC));
    drain();
    chk("w4_xfers", 32'(xfers), 32'd4);
    chk("w4_contig", 32'(last_cyc - first_cyc), 32'd3);

    // Back-to-back cnt=2 and cnt=3: five contiguous words
    clr_x();
    base = exp_msgs;
    send(mk(16'h0010, 16'd2, 32'h1111_0000, 32'h2, 32'h3));
    send(mk(16'h0011, 16'd3, 32'h2222_0000, 32'h2222_0001, 32'h4));
    drain();
    chk("b2b_xfers", 32'(xfers), 32'd5);
    chk("b2b_contig", 32'(last_cyc - first_cyc), 32'd4);
    chk("b2b_msgs", 32'(exp_msgs - base), 32'd2);
    chk("b2b_count", 32'(msg_count), 32'd4);

    // Backpressure mid-burst, FIFO fills
    out__RDY = 1'b0;
    send(mk(16'h0005, 16'd4, 32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003));
    tick();
    out__RDY = 1'b1;
    tick();
    out__RDY = 1'b0;
    repeat (10) tick();
    chk("bp_word", out_v, exp_q[0].w);
    chk("bp_rdy_empty", 32'(enq__RDY), 32'd1);
    send(mk(16'h0006, 16'd2, 32'h6666_0001, 32'h0, 32'h0));
    chk("bp_rdy_one", 32'(enq__RDY), 32'd1);
    send(mk(16'h0007, 16'd3, 32'h7777_0001, 32'h7777_0002, 32'h0));
    chk("bp_rdy_full", 32'(enq__RDY), 32'd0);
    enq_v    = mk(16'hDEAD, 16'd1, 32'hBAD, 32'hBAD, 32'hBAD);
    enq__ENA = 1'b1;
    repeat (3) tick();
    enq__ENA = 1'b0;
    out__RDY = 1'b1;
    drain();
    chk("bp_count", 32'(msg_count), 32'd7);

    // Illegal counts clamp to four words and set the sticky flag
    chk("ill_lenerr_pre", 32'(len_err), 32'd0);
    clr_x();
    send(mk(16'h0020, 16'd0, 32'hC0, 32'hC1, 32'hC2));
    send(mk(16'h0021, 16'd9, 32'hD0, 32'hD1, 32'hD2));
    drain();
    chk("ill_xfers", 32'(xfers), 32'd8);
    chk("ill_lenerr", 32'(len_err), 32'(exp_len_err));

    // Random messages with random sink stalls
    rand_rdy = 1'b1;
    for (int n = 0; n < 24; n++) begin
      send(mk(16'($urandom), 16'($urandom_range(0, 6)), $urandom, $urandom, $urandom));
    end
    rand_rdy = 1'b0;
    out__RDY = 1'b1;
    drain();
    chk("rnd_count", 32'(msg_count), 32'(exp_msgs[15:0]));
    chk("rnd_lenerr", 32'(len_err), 32'(exp_len_err));

    // Asynchronous reset during word 2 of 4
    send(mk(16'h0007, 16'd4, 32'h7000_0001, 32'h7000_0002, 32'h7000_0003));
    tick();
    tick();
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_ena", 32'(out__ENA), 32'd0);
    chk("arst_v", out_v, 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    chk("arst_count", 32'(msg_count), 32'd0);
    chk("arst_lenerr", 32'(len_err), 32'd0);
    chk("arst_rdy", 32'(enq__RDY), 32'd0);
    exp_q.delete();
    exp_msgs    = 0;
    exp_len_err = 1'b0;
    hold        = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    clr_x();
    send(mk(16'h0030, 16'd1, 32'h0, 32'h0, 32'h0));
    drain();
    chk("post_xfers", 32'(xfers), 32'd1);
    chk("post_count", 32'(msg_count), 32'd1);
    chk("post_lenerr", 32'(len_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
